// File: rtl/color_emu_pkg.sv
// color_emu_pkg: shared definitions for the color sensor frequency emulator.
//   - Filter codes applied on the 'filter' output (FILT_RED..FILT_CLEAR).
//   - Output-generator state encoding (state_t).
//   - decode_filter(): maps the reader's {s2,s3} select pair to a filter code.
package color_emu_pkg;

  localparam logic [1:0] FILT_RED   = 2'd0;
  localparam logic [1:0] FILT_GREEN = 2'd1;
  localparam logic [1:0] FILT_BLUE  = 2'd2;
  localparam logic [1:0] FILT_CLEAR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HIGH,
    ST_LOW
  } state_t;

  // {s2,s3}: 00 red, 11 green, 01 blue, 10 clear
  function automatic logic [1:0] decode_filter(input logic s2, input logic s3);
    logic [1:0] code;
    case ({s2, s3})
      2'b00:   code = FILT_RED;
      2'b11:   code = FILT_GREEN;
      2'b01:   code = FILT_BLUE;
      default: code = FILT_CLEAR;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2: one-bit, two-flop synchronizer for signals asynchronous to clk.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, clears both flops
//   d   - asynchronous input
//   q   - synchronized output (two clk cycles of latency)
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/color_freq_emulator.sv
// color_freq_emulator: emulates a color light-to-frequency sensor. The reader
// selects a filter with s2/s3; the block answers with a square wave whose
// half-period (in clk cycles) is taken from the matching hp_* input.
// Parameters:
//   W          - width of half-period inputs and period counter
//   SETTLE_CYC - clk cycles freq_out is held low after a (re)start
// Ports:
//   clk, rst                             - clock, async active-high reset
//   enable                               - 1 = emulate, 0 = output off
//   s2, s3                               - filter select (async to clk)
//   hp_red, hp_green, hp_blue, hp_clear  - half-period per filter
//   freq_out                             - emulated square wave
//   filter                               - currently applied filter code
//   active                               - high while toggling
//   pulse_count                          - rising-edge counter (optional)
// Optional feature: define COLOR_EMU_PULSE_CNT_EN to add pulse_count, a
// saturating 16-bit count of freq_out rising edges since the last filter
// change or enable rise.
module color_freq_emulator
  import color_emu_pkg::*;
#(
  parameter int unsigned W          = 9,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         s2,
  input  logic         s3,
  input  logic [W-1:0] hp_red,
  input  logic [W-1:0] hp_green,
  input  logic [W-1:0] hp_blue,
  input  logic [W-1:0] hp_clear,
  output logic         freq_out,
  output logic [1:0]   filter,
  output logic         active
`ifdef COLOR_EMU_PULSE_CNT_EN
  ,
  output logic [15:0]  pulse_count
`endif
);

  localparam int unsigned SW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

  logic         s2_sync;
  logic         s3_sync;
  logic [1:0]   sel_code;
  logic         chg_q;
  logic [W-1:0] hp_sel;

  state_t       state, state_n;
  logic [W-1:0] per_cnt, per_cnt_n;
  logic [SW-1:0] set_cnt, set_cnt_n;

  sync2 u_sync_s2 (
    .clk (clk),
    .rst (rst),
    .d   (s2),
    .q   (s2_sync)
  );

  sync2 u_sync_s3 (
    .clk (clk),
    .rst (rst),
    .d   (s3),
    .q   (s3_sync)
  );

  assign sel_code = decode_filter(s2_sync, s3_sync);

  // filter follows the synchronized select unconditionally (also while
  // disabled); chg_q flags the cycle right after it moved, which is the
  // cycle the generator restarts from.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filter <= FILT_RED;
      chg_q  <= 1'b0;
    end else begin
      filter <= sel_code;
      chg_q  <= (sel_code != filter);
    end
  end

  always_comb begin
    case (filter)
      FILT_RED:   hp_sel = hp_red;
      FILT_GREEN: hp_sel = hp_green;
      FILT_BLUE:  hp_sel = hp_blue;
      default:    hp_sel = hp_clear;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      per_cnt <= '0;
      set_cnt <= '0;
    end else begin
      state   <= state_n;
      per_cnt <= per_cnt_n;
      set_cnt <= set_cnt_n;
    end
  end

  // A reload samples hp_sel; a zero half-period parks in LOW with a zero
  // counter, which re-enters the reload path every cycle until it is nonzero.
  always_comb begin
    state_n   = state;
    per_cnt_n = per_cnt;
    set_cnt_n = set_cnt;
    if (!enable) begin
      state_n   = ST_IDLE;
      per_cnt_n = '0;
      set_cnt_n = '0;
    end else if (state == ST_IDLE || chg_q) begin
      if (SETTLE_CYC == 0) begin
        state_n   = (hp_sel != '0) ? ST_HIGH : ST_LOW;
        per_cnt_n = hp_sel;
      end else begin
        state_n   = ST_SETTLE;
        set_cnt_n = SW'(SETTLE_CYC);
        per_cnt_n = '0;
      end
    end else begin
      case (state)
        ST_SETTLE: begin
          if (set_cnt <= SW'(1)) begin
            state_n   = (hp_sel != '0) ? ST_HIGH : ST_LOW;
            per_cnt_n = hp_sel;
            set_cnt_n = '0;
          end else begin
            set_cnt_n = set_cnt - 1'b1;
          end
        end
        ST_HIGH: begin
          if (per_cnt <= W'(1)) begin
            state_n   = ST_LOW;
            per_cnt_n = hp_sel;
          end else begin
            per_cnt_n = per_cnt - 1'b1;
          end
        end
        ST_LOW: begin
          if (per_cnt <= W'(1)) begin
            state_n   = (hp_sel != '0) ? ST_HIGH : ST_LOW;
            per_cnt_n = hp_sel;
          end else begin
            per_cnt_n = per_cnt - 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // Output is forced low in the cycle the restart is being taken.
  assign freq_out = (state == ST_HIGH) && !chg_q;
  assign active   = ((state == ST_HIGH) || (state == ST_LOW)) && (per_cnt != '0);

`ifdef COLOR_EMU_PULSE_CNT_EN
  logic        freq_q;
  logic        en_q;
  logic [15:0] pcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_q <= 1'b0;
      en_q   <= 1'b0;
      pcnt   <= '0;
    end else begin
      freq_q <= freq_out;
      en_q   <= enable;
      if ((sel_code != filter) || (enable && !en_q)) begin
        pcnt <= '0;
      end else if (freq_out && !freq_q && (pcnt != '1)) begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

  assign pulse_count = pcnt;
`endif

endmodule

// File: doc/color_freq_emulator.md
COLOR_FREQ_EMULATOR -- requirements
Module: color_freq_emulator

Interface
REQ-001 SHALL have parameter W, default 9, width of half-period inputs and internal period counter.
REQ-002 SHALL have parameter SETTLE_CYC, default 4, clk cycles freq_out is held low after a filter change.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port enable  input  1  1 = emulate sensor output, 0 = output off.
REQ-006 SHALL have port s2  input  1  filter select bit from reader, asynchronous to clk.
REQ-007 SHALL have port s3  input  1  filter select bit from reader, asynchronous to clk.
REQ-008 SHALL have ports hp_red, hp_green, hp_blue, hp_clear  input  W each  half-period in clk cycles per filter.
REQ-009 SHALL have port freq_out  output  1  emulated sensor square wave, fed to the reader's c_clk.
REQ-010 SHALL have port filter  output  2  currently applied filter code.
REQ-011 SHALL have port active  output  1  high while toggling (states HIGH/LOW with nonzero half-period).

Function
REQ-012 SHALL pass s2, s3 through a two-flop synchronizer before any use.
REQ-013 SHALL decode synchronized {s2,s3}: 00 red (code 0), 11 green (code 1), 01 blue (code 2), 10 clear (code 3).
REQ-014 SHALL implement states IDLE, SETTLE, HIGH, LOW.
REQ-015 IDLE: freq_out=0, active=0; enable=1 -> SETTLE, settle counter loaded with SETTLE_CYC.
REQ-016 SETTLE: freq_out=0; counter decrements each cycle; on last settle cycle, load period counter with selected half-period, enter HIGH if half-period nonzero, else LOW.
REQ-017 HIGH: freq_out=1 for exactly hp cycles, then LOW with period counter reloaded from the current selected half-period.
REQ-018 LOW: freq_out=0 for exactly hp cycles, then HIGH with reload; half-period sampled only at each reload, so mid-phase changes take effect at next boundary.
REQ-019 Half-period 0 at reload: stay in LOW, freq_out=0, active=0, re-sample every cycle; first nonzero value -> HIGH next cycle.
REQ-020 Synchronized filter code differing from the registered filter: filter updates, state -> SETTLE next cycle from any non-IDLE state, freq_out=0 that cycle.
REQ-021 enable=0 in any state: IDLE next cycle, freq_out=0; filter keeps tracking the synchronized input.
REQ-022 Filter change and enable fall in the same cycle: enable wins (IDLE).
REQ-023 Latency s2/s3 input edge to filter update SHALL be 3 clk cycles; to first freq_out rise SHALL be 3+SETTLE_CYC+1 cycles.
REQ-024 Period counter SHALL be W bits, unsigned, never wraps (reloads at 1 before reaching 0).
REQ-025 SETTLE_CYC=0 SHALL skip SETTLE (direct reload on change).

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, freq_out=0, active=0, filter=0, counters 0, synchronizer flops 0.
REQ-027 rst asserted mid-phase SHALL drop freq_out within the same cycle (asynchronous); after release, behaviour per REQ-015.

Configuration
REQ-028 Macro COLOR_EMU_PULSE_CNT_EN defined: SHALL add output pulse_count (16 bits), counting freq_out rising edges since last filter change or enable rise, saturating at 16'hFFFF, reset to 0.
REQ-029 Macro undefined: SHALL have no pulse_count port and no counter logic.

Structure
REQ-030 Shared package color_emu_pkg SHALL hold filter code constants (FILT_RED..FILT_CLEAR) and the state encoding.
REQ-031 Synchronizer SHALL be sub-module sync2 (one-bit, two-flop, async active-high reset), instantiated twice.

Verification
REQ-032 Reset, enable=1, s2=s3=0, hp_red=5, SETTLE_CYC=4 -> freq_out low 4 cycles, then 5 high / 5 low repeating, filter=0.
REQ-033 While toggling red, switch to s2=s3=1, hp_green=3 -> filter=1 after 3 cycles, freq_out low 4 cycles, then 3/3 square wave.
REQ-034 hp_blue=0, select blue -> freq_out stays 0, active=0; set hp_blue=2 -> HIGH next cycle, 2/2 wave.
REQ-035 Change hp_red 5->8 midway through a HIGH phase -> current phase completes at 5, next LOW phase lasts 8.
REQ-036 Assert rst during HIGH -> freq_out 0 same cycle; release -> SETTLE then normal toggling.
REQ-037 With COLOR_EMU_PULSE_CNT_EN, hp_clear=1 for 200000 cycles -> pulse_count saturates at 65535; filter change -> 0.
